// File: rtl/sync_decade_down_counter_pkg.sv
// rtl/sync_decade_down_counter_pkg.sv - shared BCD digit types, constants and clamp helper
package sync_decade_down_counter_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  function automatic bcd_digit_t bcd_sat(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/sync_decade_down_counter_digit.sv
// rtl/sync_decade_down_counter_digit.sv - one decade digit with decrement, wrap/reload and borrow-out
module bcd_down_digit
  import sync_decade_down_counter_pkg::*;
(
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic [BCD_W-1:0] din,
  input  logic [BCD_W-1:0] rld,
  input  logic             use_rld,
  input  logic             bin,
  output logic [BCD_W-1:0] q,
  output logic             bout
);

  bcd_digit_t q_r;

  assign q = q_r;

  // A zero digit that is asked to borrow passes the borrow upward.
  always_comb begin
    bout = bin && (q_r == '0);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      q_r <= '0;
    end else if (load) begin
      q_r <= bcd_sat(din);
    end else if (bin) begin
      // use_rld is only raised when every digit is zero, so all digits reload together.
      if (use_rld) begin
        q_r <= rld;
      end else if (q_r == '0) begin
        q_r <= BCD_MAX;
      end else begin
        q_r <= q_r - 4'd1;
      end
    end
  end

endmodule

// File: rtl/sync_decade_down_counter.sv
// rtl/sync_decade_down_counter.sv - synchronous multi-digit BCD down counter with zero detect and underflow strobe
module sync_decade_down_counter
  import sync_decade_down_counter_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter bit RELOAD = 1'b0
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   q,
  output logic                  zero,
  output logic                  tc
);

  logic [4*DIGITS-1:0] rld;
  logic [DIGITS:0]     borrow;
  logic                use_rld;

  assign borrow[0] = en;
  assign zero      = (q == '0);
  assign use_rld   = (RELOAD != 1'b0) && zero;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_down_digit u_digit (
      .clk     (clk),
      .res     (res),
      .load    (load),
      .din     (din[BCD_W*k +: BCD_W]),
      .rld     (rld[BCD_W*k +: BCD_W]),
      .use_rld (use_rld),
      .bin     (borrow[k]),
      .q       (q[BCD_W*k +: BCD_W]),
      .bout    (borrow[k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (res) begin
      rld <= '0;
    end else if (load) begin
      for (int k = 0; k < DIGITS; k++) begin
        rld[BCD_W*k +: BCD_W] <= bcd_sat(din[BCD_W*k +: BCD_W]);
      end
    end
  end

  // Borrow out of the top digit is exactly "enabled while all zero", i.e. underflow.
  always_ff @(posedge clk) begin
    if (res) begin
      tc <= 1'b0;
    end else begin
      tc <= !load && borrow[DIGITS];
    end
  end

endmodule

// File: tb/tb_sync_decade_down_counter.sv
// tb/tb_sync_decade_down_counter.sv - scoreboard bench for wrap and reload variants of the BCD down counter
module tb_sync_decade_down_counter;

  logic       clk;
  logic       res;
  logic       load;
  logic       en;
  logic [7:0] din;
  logic [7:0] q_w, q_r;
  logic       zero_w, zero_r, tc_w, tc_r;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] qw;
    logic       tw;
    logic [7:0] qr;
    logic       tr;
  } exp_t;

  exp_t sb[$];

  int mv_w, mv_r, mrld;
  logic mtc_w, mtc_r;

  sync_decade_down_counter #(.DIGITS(2), .RELOAD(1'b0)) u_wrap (
    .clk(clk), .res(res), .load(load), .din(din), .en(en),
    .q(q_w), .zero(zero_w), .tc(tc_w)
  );

  sync_decade_down_counter #(.DIGITS(2), .RELOAD(1'b1)) u_rld (
    .clk(clk), .res(res), .load(load), .din(din), .en(en),
    .q(q_r), .zero(zero_r), .tc(tc_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clamp_int(input logic [7:0] d);
    logic [3:0] hi, lo;
    hi = d[7:4];
    lo = d[3:0];
    if (hi > 4'd9) hi = 4'd9;
    if (lo > 4'd9) lo = 4'd9;
    return int'(hi) * 10 + int'(lo);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  // Decimal reference model; expectations pushed as each command is driven.
  task automatic drive(input logic r, input logic l, input logic e, input logic [7:0] d);
    exp_t x;
    @(negedge clk);
    res = r; load = l; en = e; din = d;
    if (r) begin
      mv_w = 0; mv_r = 0; mrld = 0; mtc_w = 0; mtc_r = 0;
    end else if (l) begin
      mv_w = clamp_int(d); mv_r = mv_w; mrld = mv_w; mtc_w = 0; mtc_r = 0;
    end else if (e) begin
      mtc_w = (mv_w == 0);
      mv_w  = (mv_w == 0) ? 99 : mv_w - 1;
      mtc_r = (mv_r == 0);
      mv_r  = (mv_r == 0) ? mrld : mv_r - 1;
    end else begin
      mtc_w = 0; mtc_r = 0;
    end
    x.qw = int2bcd(mv_w); x.tw = mtc_w; x.qr = int2bcd(mv_r); x.tr = mtc_r;
    sb.push_back(x);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (q_w !== e.qw || tc_w !== e.tw || zero_w !== (e.qw == 8'h00)) begin
        errors++;
        $display("FAIL sb_wrap q=%h tc=%b zero=%b expected q=%h tc=%b", q_w, tc_w, zero_w, e.qw, e.tw);
      end
      checks++;
      if (q_r !== e.qr || tc_r !== e.tr || zero_r !== (e.qr == 8'h00)) begin
        errors++;
        $display("FAIL sb_reload q=%h tc=%b zero=%b expected q=%h tc=%b", q_r, tc_r, zero_r, e.qr, e.tr);
      end
    end
  end

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 8'h55);
      checks++;
      if (q_w !== 8'h00 || zero_w !== 1'b1 || tc_w !== 1'b0 || q_r !== 8'h00 || tc_r !== 1'b0) begin
        errors++;
        $display("FAIL reset q_w=%h zero=%b tc=%b q_r=%h expected 00 1 0 00", q_w, zero_w, tc_w, q_r);
      end
    end
  endtask

  task automatic test_wrap;
    logic [7:0] want;
    drive(1'b0, 1'b1, 1'b0, 8'h12);
    for (int i = 0; i < 13; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      want = (i < 12) ? int2bcd(11 - i) : 8'h99;
      checks++;
      if (q_w !== want || tc_w !== (i == 12)) begin
        errors++;
        $display("FAIL wrap step %0d q=%h tc=%b expected q=%h tc=%b", i, q_w, tc_w, want, (i == 12));
      end
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (q_w !== 8'h99 || tc_w !== 1'b0) begin
      errors++;
      $display("FAIL wrap_hold q=%h tc=%b expected q=99 tc=0", q_w, tc_w);
    end
  endtask

  task automatic test_clamp;
    drive(1'b0, 1'b1, 1'b0, 8'h3C);
    checks++;
    if (q_w !== 8'h39) begin
      errors++;
      $display("FAIL clamp_load q=%h expected 39", q_w);
    end
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    checks++;
    if (q_w !== 8'h38) begin
      errors++;
      $display("FAIL clamp_count q=%h expected 38", q_w);
    end
    drive(1'b0, 1'b1, 1'b0, 8'hFA);
    checks++;
    if (q_r !== 8'h99) begin
      errors++;
      $display("FAIL clamp_both q=%h expected 99", q_r);
    end
  endtask

  task automatic test_reload;
    drive(1'b0, 1'b1, 1'b0, 8'h05);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 8'h00);
      checks++;
      if (q_r !== 8'h00 || zero_r !== 1'b1) begin
        errors++;
        $display("FAIL reload_zero pass %0d q=%h zero=%b expected 00 1", pass, q_r, zero_r);
      end
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      checks++;
      if (q_r !== 8'h05 || tc_r !== 1'b1) begin
        errors++;
        $display("FAIL reload_wrap pass %0d q=%h tc=%b expected 05 1", pass, q_r, tc_r);
      end
    end
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    checks++;
    if (q_r !== 8'h04 || tc_r !== 1'b0) begin
      errors++;
      $display("FAIL reload_pulse q=%h tc=%b expected 04 0", q_r, tc_r);
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      checks++;
      if (q_r !== 8'h00 || tc_r !== 1'b1) begin
        errors++;
        $display("FAIL reload_of_zero step %0d q=%h tc=%b expected 00 1", i, q_r, tc_r);
      end
    end
  endtask

  task automatic test_gated_en;
    drive(1'b0, 1'b1, 1'b0, 8'h20);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    checks++;
    if (q_w !== 8'h19) begin
      errors++;
      $display("FAIL gated_first q=%h expected 19", q_w);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (q_w !== 8'h19 || tc_w !== 1'b0) begin
      errors++;
      $display("FAIL gated_hold q=%h tc=%b expected 19 0", q_w, tc_w);
    end
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    checks++;
    if (q_w !== 8'h18) begin
      errors++;
      $display("FAIL gated_second q=%h expected 18", q_w);
    end
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 8'h47);
    checks++;
    if (q_w !== 8'h47 || tc_w !== 1'b0 || q_r !== 8'h47 || tc_r !== 1'b0) begin
      errors++;
      $display("FAIL load_over_underflow q=%h/%h tc=%b/%b expected 47 tc 0", q_w, q_r, tc_w, tc_r);
    end
  endtask

  task automatic test_reset_mid;
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    checks++;
    if (q_w !== 8'h00 || tc_w !== 1'b0 || q_r !== 8'h00 || tc_r !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid q=%h/%h tc=%b/%b expected 00 tc 0", q_w, q_r, tc_w, tc_r);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (tc_w !== 1'b0 || tc_r !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after tc=%b/%b expected 0", tc_w, tc_r);
    end
  endtask

  initial begin
    res = 1'b1; load = 1'b0; en = 1'b0; din = 8'h00;
    test_reset;
    test_wrap;
    test_clamp;
    test_reload;
    test_gated_en;
    test_reset_mid;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
